// File: rtl/mpadd_pkg.sv
// Shared definitions for the sequential multi-precision adder: FSM encoding and default sizing.
package mpadd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned CHUNK_DEF  = 32;
  localparam int unsigned NCHUNK_DEF = 4;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in/out.
// With MPADD_SEQ_OVF_EN defined it also exports the carry into the slice MSB.
module chunk_adder #(
  parameter int unsigned CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
`ifdef MPADD_SEQ_OVF_EN
  output logic             cm,
`endif
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign s    = full[CHUNK-1:0];
  assign co   = full[CHUNK];

`ifdef MPADD_SEQ_OVF_EN
  // The MSB sum bit is a ^ b ^ carry_in, so the carry in can be recovered from it.
  assign cm = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
`endif

endmodule

// File: rtl/mpadd_seq.sv
// Sequential W-bit add/subtract, one CHUNK-bit slice per cycle, valid/ready on both sides.
// Define MPADD_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int unsigned CHUNK  = CHUNK_DEF,
  parameter int unsigned NCHUNK = NCHUNK_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHUNK*NCHUNK-1:0] op_a,
  input  logic [CHUNK*NCHUNK-1:0] op_b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHUNK*NCHUNK-1:0] sum,
`ifdef MPADD_SEQ_OVF_EN
  output logic                    ovf,
`endif
  output logic                    co
);

  localparam int unsigned W    = CHUNK * NCHUNK;
  localparam int unsigned IDXW = $clog2(NCHUNK + 1);

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            co_q;
  logic [IDXW-1:0] idx_q;
  logic            last;
  int unsigned     base;

  logic [CHUNK-1:0] sl_s;
  logic             sl_co;
`ifdef MPADD_SEQ_OVF_EN
  logic             sl_cm;
  logic             ovf_q;
`endif

  assign base = 32'(idx_q) * CHUNK;
  assign last = (idx_q == IDXW'(NCHUNK - 1));

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a  (a_q[base +: CHUNK]),
    .b  (b_q[base +: CHUNK]),
    .ci (carry_q),
`ifdef MPADD_SEQ_OVF_EN
    .cm (sl_cm),
`endif
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
`ifdef MPADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            // Subtraction is A + ~B + 1; the +1 enters through the carry register.
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[base +: CHUNK] <= sl_s;
          carry_q              <= sl_co;
          if (last) begin
            co_q    <= sl_co;
`ifdef MPADD_SEQ_OVF_EN
            ovf_q   <= sl_cm ^ sl_co;
`endif
            idx_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign co        = co_q;
`ifdef MPADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: doc/mpadd_seq.md
MPADD_SEQ -- requirements
Module: mpadd_seq

Interface
REQ-001 The block SHALL have parameter CHUNK, default 32, giving the width of the single adder slice used each cycle.
REQ-002 The block SHALL have parameter NCHUNK, default 4, giving the number of slices per operand (operand width W = CHUNK*NCHUNK, NCHUNK >= 1).
REQ-003 The block SHALL have port clk, input, 1, the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, which signals that a request is offered.
REQ-006 The block SHALL have port in_ready, output, 1, which signals that the block can accept a request.
REQ-007 The block SHALL have port op_a, input, W, operand A.
REQ-008 The block SHALL have port op_b, input, W, operand B.
REQ-009 The block SHALL have port sub, input, 1, selecting the operation: 0 = A+B, 1 = A-B.
REQ-010 The block SHALL have port out_valid, output, 1, which signals that a result is held.
REQ-011 The block SHALL have port out_ready, input, 1, which signals that the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, W, the result.
REQ-013 The block SHALL have port co, output, 1, the carry out of the MSB (for sub: 1 = no borrow).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, an accept occurs when in_valid && in_ready; on the accepting edge the block SHALL:
  - latch op_a;
  - latch op_b, bitwise-inverted when sub = 1;
  - load the carry register with sub;
  - clear the slice index to 0;
  - enter RUN.
REQ-017 Each RUN cycle SHALL add slice[idx] of A, slice[idx] of B' and the carry register.
  - The sum is written to slice idx of the result register.
  - The carry-out is written to the carry register.
  - idx increments.
REQ-018 When the slice just processed has idx = NCHUNK-1, the next state SHALL be DONE.
REQ-019 Latency SHALL be fixed: for an accept at edge k, out_valid rises at edge k+NCHUNK, independent of the data.
REQ-020 In DONE, sum and co SHALL be held stable until out_valid && out_ready, after which the block returns to IDLE on that edge.
REQ-021 in_ready SHALL stay 0 from the accept until the edge after the output handshake, so at most one request is in flight and back-to-back throughput is NCHUNK+1 cycles per result when out_ready is held at 1.
REQ-022 in_valid and the operand inputs SHALL be ignored outside IDLE.
REQ-023 Arithmetic SHALL be modulo 2^W, and co SHALL equal bit W of A + B' + sub.
REQ-024 With NCHUNK = 1, the block SHALL pass through RUN for exactly one cycle.
REQ-025 The slice index SHALL be ceil(log2(NCHUNK+1)) bits wide and SHALL never exceed NCHUNK-1 while in RUN.

Reset
REQ-026 Assertion of rst_n = 0 SHALL take effect immediately and asynchronously.
  - state = IDLE.
  - in_ready = 1 after release; out_valid = 0.
  - sum = 0, co = 0, carry register = 0, idx = 0.
  - ovf = 0 when present.
REQ-027 Reset during RUN or DONE SHALL abort the operation, with no partial result visible after release.

Configuration
REQ-028 Macro MPADD_SEQ_OVF_EN SHALL control signed overflow reporting.
REQ-029 When MPADD_SEQ_OVF_EN is defined, the block SHALL add output port ovf, 1 bit, equal to the carry into bit W-1 XOR the carry out of bit W-1 for the final slice, registered with sum and held while out_valid is 1.
REQ-030 When MPADD_SEQ_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package mpadd_pkg SHALL hold:
  - the state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - the default CHUNK and NCHUNK constants.
REQ-032 The block SHALL instantiate exactly one sub-module, chunk_adder: combinational, CHUNK-bit a/b/ci in, s/co out, plus carry-into-MSB out when MPADD_SEQ_OVF_EN is defined.
  - The FSM, operand registers, result register and index counter reside in mpadd_seq.

Verification
REQ-033 The bench SHALL cover reset release:
  - stimulus: CHUNK = 8, NCHUNK = 4; reset released; in_valid = 0.
  - response: in_ready = 1, out_valid = 0, sum = 0.
REQ-034 The bench SHALL cover an add with ripple across every slice:
  - stimulus: A = 0x00FF_FFFF, B = 0x0000_0001, sub = 0, accept at edge k.
  - response: out_valid at edge k+4; sum = 0x0100_0000; co = 0.
REQ-035 The bench SHALL cover a subtract with borrow:
  - stimulus: A = 0x0000_0000, B = 0x0000_0001, sub = 1.
  - response: sum = 0xFFFF_FFFF; co = 0; ovf = 0 when enabled.
REQ-036 The bench SHALL cover signed overflow:
  - stimulus: A = 0x7FFF_FFFF, B = 0x0000_0001, sub = 0.
  - response: sum = 0x8000_0000; co = 0; ovf = 1 with MPADD_SEQ_OVF_EN.
REQ-037 The bench SHALL cover backpressure:
  - stimulus: result ready with out_ready = 0 for 5 cycles; new in_valid applied.
  - response: sum stable; in_ready = 0; the new request accepted only after the handshake.
REQ-038 The bench SHALL cover reset mid-operation:
  - stimulus: rst_n pulsed low in the 2nd RUN cycle.
  - response: IDLE immediately; out_valid never asserted for the aborted request; the next request completes correctly.
